// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: stage bit positions, stall FSM encodings
// and the NOP used when a stage register is bubbled.
package pipe_stall_ctrl_pkg;

    localparam int XLEN = 32;

    localparam int STG_IF  = 4;
    localparam int STG_ID  = 3;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 0;
    localparam int NUM_STAGES = STG_IF + 1;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_STALL   = 2'b01,
        ST_FLUSH   = 2'b10,
        ST_MEMWAIT = 2'b11
    } stall_state_t;

    localparam logic [NUM_STAGES-1:0] EN_ALL     = '1;
    localparam logic [NUM_STAGES-1:0] EN_WB_ONLY = NUM_STAGES'(1 << STG_WB);
    localparam logic [NUM_STAGES-1:0] BUB_ID     = NUM_STAGES'(1 << STG_ID);
    localparam logic [NUM_STAGES-1:0] BUB_WB     = NUM_STAGES'(1 << STG_WB);

    // Value a pipeline register loads when its bubble control is set.
    function automatic logic [XLEN-1:0] stage_insn(input logic [XLEN-1:0] insn,
                                                   input logic            bub);
        return bub ? NOP_INSN : insn;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_mask.sv
// Thermometer normalisation of a stage halt vector: every stage from IF down to
// the lowest requested stage is frozen, and the stage just below gets a bubble.
module stall_mask_gen
    import pipe_stall_ctrl_pkg::*;
(
    input  logic [NUM_STAGES-1:0] halt_req,
    output logic [NUM_STAGES-1:0] frozen,
    output logic [NUM_STAGES-1:0] bubble
);

    always_comb begin
        frozen    = '0;
        bubble    = '0;
        frozen[0] = halt_req[0];
        for (int i = 1; i < NUM_STAGES; i++) begin
            frozen[i] = frozen[i-1] | halt_req[i];
        end
        for (int i = 0; i < NUM_STAGES - 1; i++) begin
            bubble[i] = frozen[i+1] & ~frozen[i];
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Arbitrates memory wait, branch flush and hazard stall into per-stage
// register enables, bubble controls and the PC redirect strobe.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   RUN     | free-running, or first cycle of any new event
//   STALL   | hazard stall in progress, thermometer mask from halt_req
//   FLUSH   | squashing ID for the remaining post-branch cycles
//   MEMWAIT | everything but WB frozen until data memory is ready
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] halt_req,
    input  logic                  taken_branch,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] bubble,
    output logic                  pc_redirect,
    output logic [1:0]            state,
    output logic [3:0]            stall_cnt,
    output logic                  stall_timeout
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    stall_state_t          cur_state, state_nxt;
    logic [3:0]            flush_cnt, flush_nxt;
    logic [3:0]            cnt_nxt, cnt_inc;
    logic                  branch_pend, pend_nxt;
    logic                  timeout_nxt;
    logic                  mem_wait, br_eff;
    logic                  do_branch, enter_wait;
    logic [NUM_STAGES-1:0] frozen, mask_bubble;

    stall_mask_gen u_mask (
        .halt_req (halt_req),
        .frozen   (frozen),
        .bubble   (mask_bubble)
    );

    assign mem_wait = dmem_req & ~dmem_ready;
    assign br_eff   = taken_branch | branch_pend;
    assign state    = cur_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state     <= ST_RUN;
            flush_cnt     <= '0;
            stall_cnt     <= '0;
            branch_pend   <= 1'b0;
            stall_timeout <= 1'b0;
        end else begin
            cur_state     <= state_nxt;
            flush_cnt     <= flush_nxt;
            stall_cnt     <= cnt_nxt;
            branch_pend   <= pend_nxt;
            stall_timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = cur_state;
        flush_nxt   = flush_cnt;
        cnt_nxt     = stall_cnt;
        pend_nxt    = branch_pend;
        timeout_nxt = stall_timeout;
        stage_en    = EN_ALL;
        bubble      = '0;
        pc_redirect = 1'b0;
        do_branch   = 1'b0;
        enter_wait  = 1'b0;
        cnt_inc     = (stall_cnt == 4'hF) ? stall_cnt : stall_cnt + 4'd1;

        case (cur_state)
            ST_RUN, ST_STALL: begin
                if (mem_wait) begin
                    enter_wait = 1'b1;
                // A branch cannot redirect while EX is held; it waits in branch_pend.
                end else if (br_eff && !(cur_state == ST_STALL && frozen[STG_EX])) begin
                    do_branch = 1'b1;
                end else begin
                    pend_nxt = br_eff;
                    stage_en = ~frozen;
                    bubble   = mask_bubble;
                    if (halt_req == '0) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else if (int'(cnt_inc) >= MAX_STALL) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = ST_RUN;
                        cnt_nxt     = '0;
                    end else begin
                        state_nxt = ST_STALL;
                        cnt_nxt   = cnt_inc;
                    end
                end
            end
            ST_FLUSH: begin
                if (mem_wait) begin
                    enter_wait = 1'b1;
                end else if (taken_branch) begin
                    do_branch = 1'b1;
                end else begin
                    bubble = BUB_ID;
                    if (flush_cnt <= 4'd1) begin
                        state_nxt = ST_RUN;
                        flush_nxt = '0;
                    end else begin
                        flush_nxt = flush_cnt - 4'd1;
                    end
                end
            end
            ST_MEMWAIT: begin
                if (taken_branch) pend_nxt = 1'b1;
                if (mem_wait) begin
                    stage_en = EN_WB_ONLY;
                    bubble   = BUB_WB;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        if (enter_wait) begin
            stage_en  = EN_WB_ONLY;
            bubble    = BUB_WB;
            state_nxt = ST_MEMWAIT;
            flush_nxt = '0;
            cnt_nxt   = '0;
            pend_nxt  = br_eff;
        end

        if (do_branch) begin
            pc_redirect = 1'b1;
            stage_en    = EN_ALL;
            bubble      = BUB_ID;
            flush_nxt   = FLUSH_LOAD;
            state_nxt   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            pend_nxt    = 1'b0;
            cnt_nxt     = '0;
        end

        if (!rst) begin
            stage_en    = '0;
            bubble      = '0;
            pc_redirect = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus a random
// halt_req sweep checked against an arithmetic model of the stall rules.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] halt_req;
    logic       taken_branch, dmem_req, dmem_ready;
    logic [4:0] stage_en, bubble;
    logic       pc_redirect;
    logic [1:0] state;
    logic [3:0] stall_cnt;
    logic       stall_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_stall_ctrl #(.FLUSH_CYCLES(2), .MAX_STALL(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .halt_req      (halt_req),
        .taken_branch  (taken_branch),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .stage_en      (stage_en),
        .bubble        (bubble),
        .pc_redirect   (pc_redirect),
        .state         (state),
        .stall_cnt     (stall_cnt),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] h, input logic t, input logic q, input logic r);
        halt_req = h; taken_branch = t; dmem_req = q; dmem_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive(5'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(5'b11100, 1'b1, 1'b1, 1'b0);
        #2;
        n_cmp++; if (stage_en !== 5'b0) begin n_fail++; $display("FAIL reset_en: got %b want 00000", stage_en); end
        n_cmp++; if (bubble !== 5'b0) begin n_fail++; $display("FAIL reset_bubble: got %b want 00000", bubble); end
        n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b want 0", pc_redirect); end
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (stall_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", stall_timeout); end
        drive(5'b0, 1'b0, 1'b0, 1'b0);
        #5 rst = 1'b1;
        tick();
        #2;
        n_cmp++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL reset_idle_en: got %b want 11111", stage_en); end
        tick();
    endtask

    task automatic test_load_use();
        drive(5'b11100, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++; if (stage_en !== 5'b00011) begin n_fail++; $display("FAIL load_use_en: got %b want 00011", stage_en); end
        n_cmp++; if (bubble !== 5'b00010) begin n_fail++; $display("FAIL load_use_bubble: got %b want 00010", bubble); end
        tick();
        n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL load_use_state: got %b want 01", state); end
        n_cmp++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
        drive(5'b0, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL load_use_release_en: got %b want 11111", stage_en); end
        tick();
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL load_use_back_state: got %b want 00", state); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL load_use_back_cnt: got %0d want 0", stall_cnt); end
    endtask

    // Model: a run of nonzero halt_req cycles counts up; reaching 15 trips the
    // sticky watchdog and restarts the count. Masks come from the lowest set bit.
    task automatic test_thermo_random();
        int         cnt_m = 0;
        logic       to_m = 1'b0;
        int         hold = 0;
        logic [4:0] h = 5'b0;
        logic [4:0] ones = 5'b11111;
        logic [4:0] exp_en, exp_bub;
        int         k;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (hold == 0) begin
                h    = ($urandom_range(0, 4) == 0) ? 5'b0 : 5'($urandom_range(1, 31));
                hold = $urandom_range(1, 20);
            end
            hold--;
            drive(h, 1'b0, 1'b0, 1'b0);
            if (h == 5'b0) begin
                exp_en  = 5'b11111;
                exp_bub = 5'b00000;
            end else begin
                k = 0;
                while (h[k] == 1'b0) k++;
                exp_en  = ~((ones << k) & ones);
                exp_bub = (k > 0) ? 5'(1 << (k - 1)) : 5'b0;
            end
            #2;
            n_cmp++; if (stage_en !== exp_en) begin n_fail++; $display("FAIL rand_en h=%b: got %b want %b", h, stage_en, exp_en); end
            n_cmp++; if (bubble !== exp_bub) begin n_fail++; $display("FAIL rand_bubble h=%b: got %b want %b", h, bubble, exp_bub); end
            n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL rand_redirect: got %b want 0", pc_redirect); end
            tick();
            if (h == 5'b0) cnt_m = 0;
            else if (cnt_m + 1 >= 15) begin cnt_m = 0; to_m = 1'b1; end
            else cnt_m = cnt_m + 1;
            n_cmp++; if (stall_cnt !== 4'(cnt_m)) begin n_fail++; $display("FAIL rand_cnt: got %0d want %0d", stall_cnt, cnt_m); end
            n_cmp++; if (stall_timeout !== to_m) begin n_fail++; $display("FAIL rand_timeout: got %b want %b", stall_timeout, to_m); end
            n_cmp++; if (state !== ((cnt_m != 0) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL rand_state: got %b want %b", state, (cnt_m != 0) ? 2'b01 : 2'b00); end
        end
        pulse_reset();
    endtask

    task automatic test_branch();
        drive(5'b0, 1'b1, 1'b0, 1'b0);
        #2;
        n_cmp++; if (pc_redirect !== 1'b1) begin n_fail++; $display("FAIL br_redirect0: got %b want 1", pc_redirect); end
        n_cmp++; if (bubble !== 5'b01000) begin n_fail++; $display("FAIL br_bubble0: got %b want 01000", bubble); end
        n_cmp++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL br_en0: got %b want 11111", stage_en); end
        tick();
        n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL br_state_flush: got %b want 10", state); end
        drive(5'b11111, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL br_redirect1: got %b want 0", pc_redirect); end
        n_cmp++; if (bubble !== 5'b01000) begin n_fail++; $display("FAIL br_bubble1: got %b want 01000", bubble); end
        n_cmp++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL br_en1_halt_ignored: got %b want 11111", stage_en); end
        tick();
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL br_state_run: got %b want 00", state); end
        drive(5'b0, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++; if (bubble !== 5'b0) begin n_fail++; $display("FAIL br_bubble2: got %b want 00000", bubble); end
        n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL br_redirect2: got %b want 0", pc_redirect); end
        tick();
    endtask

    task automatic test_branch_beats_halt();
        drive(5'b11100, 1'b1, 1'b0, 1'b0);
        #2;
        n_cmp++; if (pc_redirect !== 1'b1) begin n_fail++; $display("FAIL bbh_redirect: got %b want 1", pc_redirect); end
        n_cmp++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL bbh_en: got %b want 11111", stage_en); end
        n_cmp++; if (bubble !== 5'b01000) begin n_fail++; $display("FAIL bbh_bubble: got %b want 01000", bubble); end
        tick();
        n_cmp++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL bbh_cnt: got %0d want 0", stall_cnt); end
        drive(5'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL bbh_state: got %b want 00", state); end
    endtask

    task automatic test_memwait();
        for (int i = 0; i < 3; i++) begin
            drive(5'b0, 1'b0, 1'b1, 1'b0);
            #2;
            n_cmp++; if (stage_en !== 5'b00001) begin n_fail++; $display("FAIL mw_en%0d: got %b want 00001", i, stage_en); end
            n_cmp++; if (bubble !== 5'b00001) begin n_fail++; $display("FAIL mw_bubble%0d: got %b want 00001", i, bubble); end
            tick();
            n_cmp++; if (state !== 2'b11) begin n_fail++; $display("FAIL mw_state%0d: got %b want 11", i, state); end
        end
        drive(5'b0, 1'b0, 1'b1, 1'b1);
        #2;
        n_cmp++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL mw_ready_en: got %b want 11111", stage_en); end
        n_cmp++; if (bubble !== 5'b0) begin n_fail++; $display("FAIL mw_ready_bubble: got %b want 00000", bubble); end
        tick();
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL mw_exit_state: got %b want 00", state); end
        drive(5'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_branch_during_wait();
        for (int i = 0; i < 4; i++) begin
            drive(5'b0, (i == 2), 1'b1, 1'b0);
            #2;
            n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL bdw_redirect_wait%0d: got %b want 0", i, pc_redirect); end
            tick();
        end
        drive(5'b0, 1'b0, 1'b1, 1'b1);
        #2;
        n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL bdw_redirect_ready: got %b want 0", pc_redirect); end
        tick();
        drive(5'b0, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++; if (pc_redirect !== 1'b1) begin n_fail++; $display("FAIL bdw_redirect_after: got %b want 1", pc_redirect); end
        n_cmp++; if (bubble !== 5'b01000) begin n_fail++; $display("FAIL bdw_bubble_after: got %b want 01000", bubble); end
        tick();
        n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL bdw_state_flush: got %b want 10", state); end
        tick();
        #2;
        n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL bdw_single_pulse: got %b want 0", pc_redirect); end
        tick();
    endtask

    task automatic test_branch_in_stall();
        drive(5'b11100, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'b11100, 1'b1, 1'b0, 1'b0);
        #2;
        n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL bis_redirect_frozen: got %b want 0", pc_redirect); end
        n_cmp++; if (stage_en !== 5'b00011) begin n_fail++; $display("FAIL bis_en_frozen: got %b want 00011", stage_en); end
        tick();
        drive(5'b0, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++; if (pc_redirect !== 1'b1) begin n_fail++; $display("FAIL bis_redirect_release: got %b want 1", pc_redirect); end
        n_cmp++; if (bubble !== 5'b01000) begin n_fail++; $display("FAIL bis_bubble_release: got %b want 01000", bubble); end
        tick();
        tick();
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL bis_state_end: got %b want 00", state); end
    endtask

    task automatic test_watchdog();
        int exp_cnt;
        for (int c = 0; c < 20; c++) begin
            drive(5'b11000, 1'b0, 1'b0, 1'b0);
            tick();
            exp_cnt = ((c % 15) == 14) ? 0 : (c % 15) + 1;
            n_cmp++; if (stall_timeout !== (c >= 14)) begin n_fail++; $display("FAIL wd_timeout c=%0d: got %b want %b", c, stall_timeout, (c >= 14)); end
            n_cmp++; if (stall_cnt !== 4'(exp_cnt)) begin n_fail++; $display("FAIL wd_cnt c=%0d: got %0d want %0d", c, stall_cnt, exp_cnt); end
        end
        for (int c = 0; c < 3; c++) begin
            drive(5'b0, 1'b0, 1'b0, 1'b0);
            tick();
            n_cmp++; if (stall_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky%0d: got %b want 1", c, stall_timeout); end
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (stall_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_cleared: got %b want 0", stall_timeout); end
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        drive(5'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'b0, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++; if (bubble !== 5'b01000) begin n_fail++; $display("FAIL rmf_in_flush: got %b want 01000", bubble); end
        rst = 1'b0;
        #1;
        n_cmp++; if (stage_en !== 5'b0) begin n_fail++; $display("FAIL rmf_en: got %b want 00000", stage_en); end
        n_cmp++; if (bubble !== 5'b0) begin n_fail++; $display("FAIL rmf_bubble: got %b want 00000", bubble); end
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL rmf_state: got %b want 00", state); end
        #1 rst = 1'b1;
        #2;
        n_cmp++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL rmf_release_en: got %b want 11111", stage_en); end
        n_cmp++; if (bubble !== 5'b0) begin n_fail++; $display("FAIL rmf_release_bubble: got %b want 00000", bubble); end
        tick();
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL rmf_after_state: got %b want 00", state); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_thermo_random();
        test_branch();
        test_branch_beats_halt();
        test_memwait();
        test_branch_during_wait();
        test_branch_in_stall();
        test_watchdog();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer side of the hazard-unit stall interface for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Takes the registered halt vector from hazard detection, plus the taken-branch and data-memory wait signals.
- Produces per-stage pipeline-register enables, bubble (NOP-insert) controls and a PC-redirect strobe.
- Sits between hazard detection and the pipeline registers.
- Owns arbitration between memory wait, branch flush and data-hazard stall.

Parameters:
- XLEN, 32, datapath width (from shared defines).
- FLUSH_CYCLES, 2, number of cycles IF/ID are squashed after a taken branch.
- MAX_STALL, 15, watchdog limit on consecutive hazard-stall cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- halt_req  in  5  stall request; bit4=IF, bit3=ID, bit2=EX, bit1=MEM, bit0=WB
- taken_branch  in  1  branch/jump resolved taken in EX
- dmem_req  in  1  MEM stage has an outstanding data access
- dmem_ready  in  1  data memory completes the access this cycle
- stage_en  out  5  pipeline-register load enable, same bit order as halt_req
- bubble  out  5  force NOP into the stage register this cycle, same bit order
- pc_redirect  out  1  PC loads the branch target this cycle
- state  out  2  FSM state, for debug
- stall_cnt  out  4  consecutive hazard-stall cycles, saturating
- stall_timeout  out  1  sticky error flag

Behaviour:
- Reset: clk is the clock; rst is asynchronous, active-low.
  - While rst=0: stage_en=00000, bubble=00000, pc_redirect=0, state=RUN(00), stall_cnt=0, stall_timeout=0, internal flush counter=0, pending-branch flag=0.
  - Reset asserted mid-stall or mid-flush aborts it immediately.
- Timing: outputs are combinational from the current state and the inputs, so the response is zero-latency relative to halt_req. State, counters and flags are registered on posedge clk.
- Thermometer rule: halt_req is normalised to a contiguous mask from IF down to the lowest-index set bit. Example: 10100 is treated as 11100.
  - Frozen stages take stage_en=0.
  - The first stage below the mask gets bubble=1 and stage_en=1.
  - Mask 11111 freezes everything, with no bubble.
- FSM states: RUN(00), STALL(01), FLUSH(10), MEMWAIT(11).
- Priority each cycle: MEMWAIT condition > taken branch > halt_req.
- RUN:
  - No requests: stage_en=11111, bubble=00000.
  - dmem_req & !dmem_ready: stage_en=00001, bubble=00001; next state MEMWAIT.
  - taken_branch: pc_redirect=1, stage_en=11111, bubble=01000 (ID squashed); load flush counter with FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1, else RUN.
  - halt_req!=0: apply the thermometer rule; stall_cnt=1; next state STALL.
- STALL:
  - Thermometer rule applied from the live halt_req; stall_cnt increments each cycle, saturating at 15.
  - halt_req=0 returns to RUN and clears stall_cnt.
  - stall_cnt reaching MAX_STALL sets stall_timeout, forces RUN and clears stall_cnt.
  - taken_branch while EX is frozen: latch the pending-branch flag and do not redirect. On the first cycle EX is enabled, act as a taken branch (pc_redirect=1) and clear the flag.
  - taken_branch while EX is enabled: handled as in RUN.
- FLUSH:
  - bubble=01000, stage_en=11111, halt_req ignored.
  - Counter decrements each cycle; at 0, return to RUN.
  - A new taken_branch reloads the counter and pulses pc_redirect.
- MEMWAIT:
  - stage_en=00001, bubble=00001.
  - halt_req and taken_branch are held pending, not dropped: taken_branch sets the pending flag, and halt_req is re-sampled after exit.
  - Exits to RUN on the cycle after dmem_ready=1. In that dmem_ready cycle, stage_en=11111, bubble=00000.
- Simultaneous events:
  - dmem wait and taken_branch in the same cycle: the branch is latched pending and executes the first cycle after MEMWAIT.
  - taken_branch and halt_req in the same cycle in RUN: the branch wins and halt_req is discarded (the younger instructions are squashed).
- stall_timeout clears only on reset.

Decomposition:
- Shared defines gain:
  - Stage-bit indices (IF=4..WB=0).
  - FSM state encodings.
  - NOP encoding 32'h00000013 used by the bubble logic in the pipeline registers.
- One natural sub-module, stall_mask_gen: pure combinational thermometer normalisation of halt_req into frozen mask + bubble position. It is reused by the pipeline-register wrapper assertions.

Test Plan:
- Load-use: halt_req=11100 for 1 cycle in RUN -> stage_en=00011, bubble=00010, state=STALL; next cycle with halt_req=0 -> stage_en=11111, state=RUN, stall_cnt=0.
- Taken branch, FLUSH_CYCLES=2: taken_branch=1 one cycle -> pc_redirect=1, bubble=01000 for 2 consecutive cycles, then RUN with bubble=00000; pc_redirect pulses exactly once.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 -> stage_en=00001 for 3 cycles; 11111 on the ready cycle; state returns to RUN the next cycle.
- Branch during wait: taken_branch=1 in cycle 2 of MEMWAIT -> no pc_redirect during wait; pc_redirect=1 the first cycle after exit.
- Watchdog: halt_req=11000 held for 20 cycles -> stall_timeout=1 after 15 stall cycles, stays 1 until rst=0.
- Async reset mid-FLUSH: rst=0 between clock edges -> outputs go to reset values immediately; after release, first cycle in RUN with stage_en=11111.
